// File: rtl/djs130_vram_arb.sv
// DJS130 character VRAM write-port arbiter: round-robin between two display
// clients and a row-clear engine, each grant being a fixed write burst plus ack.
module djs130_vram_arb #(
    parameter int unsigned WR_CYCLES = 3,
    parameter logic [6:0]  CLR_COLS  = 7'd80,
    parameter logic [7:0]  CLR_CHAR  = 8'd32,
    parameter logic [7:0]  CLR_COLOR = 8'hff
) (
    input  logic        i_vram_clk,
    input  logic        i_vram_rst_n,
    input  logic        i_c0_req,
    input  logic [11:0] i_c0_addr,
    input  logic [15:0] i_c0_data,
    output logic        o_c0_ack,
    input  logic        i_c1_req,
    input  logic [11:0] i_c1_addr,
    input  logic [15:0] i_c1_data,
    output logic        o_c1_ack,
    input  logic        i_clr_start,
    input  logic [4:0]  i_clr_row,
    output logic        o_clr_busy,
    output logic        o_clr_done,
    output logic        o_vram_we,
    output logic        o_vram_ce,
    output logic [11:0] o_vram_addr,
    output logic [15:0] o_vram_data,
    output logic [1:0]  o_grant
);

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_ACK} state_t;

    localparam logic [1:0] G_C0  = 2'd0;
    localparam logic [1:0] G_C1  = 2'd1;
    localparam logic [1:0] G_CLR = 2'd2;
    localparam logic [3:0] WR_LOAD  = WR_CYCLES[3:0];
    localparam logic [6:0] LAST_COL = CLR_COLS - 7'd1;

    state_t      state;
    logic [1:0]  last_grant;
    logic [3:0]  wr_cnt;
    logic [6:0]  clr_col;
    logic [4:0]  clr_row;
    logic [2:0]  req;
    logic [1:0]  winner;
    logic [11:0] win_addr;
    logic [15:0] win_data;

    // The clear engine requests for as long as it is busy.
    assign req = {o_clr_busy, i_c1_req, i_c0_req};

    // Round-robin: search upward with wrap, starting after the last owner.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        winner = G_C0;
        case (last_grant)
            G_C0: begin
                if (req[1])      winner = G_C1;
                else if (req[2]) winner = G_CLR;
                else             winner = G_C0;
            end
            G_C1: begin
                if (req[2])      winner = G_CLR;
                else if (req[0]) winner = G_C0;
                else             winner = G_C1;
            end
            default: begin
                if (req[0])      winner = G_C0;
                else if (req[1]) winner = G_C1;
                else             winner = G_CLR;
            end
        endcase
    end

    always_comb begin
        win_addr = i_c0_addr;
        win_data = i_c0_data;
        case (winner)
            G_C1: begin
                win_addr = i_c1_addr;
                win_data = i_c1_data;
            end
            G_CLR: begin
                win_addr = {clr_col, clr_row};
                win_data = {CLR_COLOR, CLR_CHAR};
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_vram_clk) begin
        if (!i_vram_rst_n) begin
            state       <= ST_IDLE;
            last_grant  <= G_CLR;
            wr_cnt      <= '0;
            clr_col     <= '0;
            clr_row     <= '0;
            o_c0_ack    <= 1'b0;
            o_c1_ack    <= 1'b0;
            o_clr_busy  <= 1'b0;
            o_clr_done  <= 1'b0;
            o_vram_we   <= 1'b0;
            o_vram_ce   <= 1'b0;
            o_vram_addr <= '0;
            o_vram_data <= '0;
            o_grant     <= G_C0;
        end else begin
            o_c0_ack   <= 1'b0;
            o_c1_ack   <= 1'b0;
            o_clr_done <= 1'b0;

            // A start while busy is dropped; a busy engine never sits in ACK of its own start.
            if (i_clr_start && !o_clr_busy) begin
                clr_row    <= i_clr_row;
                clr_col    <= '0;
                o_clr_busy <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        o_vram_addr <= win_addr;
                        o_vram_data <= win_data;
                        o_grant     <= winner;
                        last_grant  <= winner;
                        wr_cnt      <= WR_LOAD;
                        o_vram_we   <= 1'b1;
                        o_vram_ce   <= 1'b1;
                        state       <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (wr_cnt == 4'd1) begin
                        o_vram_we <= 1'b0;
                        o_vram_ce <= 1'b0;
                        o_c0_ack  <= (o_grant == G_C0);
                        o_c1_ack  <= (o_grant == G_C1);
                        state     <= ST_ACK;
                    end else begin
                        wr_cnt <= wr_cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                    if (o_grant == G_CLR) begin
                        if (clr_col == LAST_COL) begin
                            o_clr_busy <= 1'b0;
                            o_clr_done <= 1'b1;
                        end else begin
                            clr_col <= clr_col + 7'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_djs130_vram_arb.sv
// Directed self-checking bench for djs130_vram_arb: single write, round-robin,
// row clear, clear under contention, start-while-busy and reset mid-operation.
module tb_djs130_vram_arb;

    localparam int          WR  = 3;
    localparam logic [11:0] A0  = 12'h03D;
    localparam logic [15:0] D0  = 16'hff41;
    localparam logic [11:0] A1  = 12'h5A3;
    localparam logic [15:0] D1  = 16'h0C42;
    localparam logic [15:0] DCL = 16'hff20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c0_req, c1_req, clr_start;
    logic [11:0] c0_addr, c1_addr;
    logic [15:0] c0_data, c1_data;
    logic [4:0]  clr_row;
    logic        c0_ack, c1_ack, clr_busy, clr_done, vram_we, vram_ce;
    logic [11:0] vram_addr;
    logic [15:0] vram_data;
    logic [1:0]  grant;

    int n_checks = 0;
    int n_pass   = 0;
    bit keep0    = 1'b0;
    bit keep1    = 1'b0;

    djs130_vram_arb dut (
        .i_vram_clk  (clk),
        .i_vram_rst_n(rst_n),
        .i_c0_req    (c0_req),
        .i_c0_addr   (c0_addr),
        .i_c0_data   (c0_data),
        .o_c0_ack    (c0_ack),
        .i_c1_req    (c1_req),
        .i_c1_addr   (c1_addr),
        .i_c1_data   (c1_data),
        .o_c1_ack    (c1_ack),
        .i_clr_start (clr_start),
        .i_clr_row   (clr_row),
        .o_clr_busy  (clr_busy),
        .o_clr_done  (clr_done),
        .o_vram_we   (vram_we),
        .o_vram_ce   (vram_ce),
        .o_vram_addr (vram_addr),
        .o_vram_data (vram_data),
        .o_grant     (grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Follows one access from grant through ack to the following IDLE cycle.
    // Returns at the negedge of the IDLE cycle after ACK.
    task automatic serve(input logic [1:0] g, input logic [11:0] a, input logic [15:0] d,
                         input bit last);
        int n;
        int wcnt;
        bit stable;
        @(negedge clk);
        clr_start = 1'b0;
        if (keep0) c0_req = 1'b1;
        if (keep1) c1_req = 1'b1;
        n = 0;
        while (vram_we !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("grant_seen", 32'(vram_we), 32'd1);
        check("grant", 32'(grant), 32'(g));
        check("addr", 32'(vram_addr), 32'(a));
        check("data", 32'(vram_data), 32'(d));
        wcnt   = 0;
        stable = 1'b1;
        while (vram_we === 1'b1 && wcnt < 20) begin
            if (vram_addr !== a || vram_data !== d || vram_ce !== 1'b1 || grant !== g ||
                c0_ack !== 1'b0 || c1_ack !== 1'b0 || (g == 2'd2 && clr_busy !== 1'b1))
                stable = 1'b0;
            wcnt++;
            @(negedge clk);
        end
        check("we_len", 32'(wcnt), 32'(WR));
        check("burst_stable", 32'(stable), 32'd1);
        check("ce_low_ack", 32'(vram_ce), 32'd0);
        check("c0_ack", 32'(c0_ack), 32'(g == 2'd0));
        check("c1_ack", 32'(c1_ack), 32'(g == 2'd1));
        if (g == 2'd0) c0_req = 1'b0;
        if (g == 2'd1) c1_req = 1'b0;
        @(negedge clk);
        check("ack_gone", 32'({c0_ack, c1_ack, vram_we}), 32'd0);
        if (g == 2'd2) begin
            check("clr_done", 32'(clr_done), 32'(last));
            check("clr_busy", 32'(clr_busy), 32'(!last));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        c0_req    = 1'b0;
        c1_req    = 1'b0;
        clr_start = 1'b0;
        clr_row   = 5'd0;
        c0_addr   = A0;
        c0_data   = D0;
        c1_addr   = A1;
        c1_data   = D1;
        repeat (3) @(negedge clk);
        check("rst_out_a", 32'({vram_we, vram_ce, grant, c0_ack, c1_ack, clr_busy, clr_done}), 32'd0);
        check("rst_out_b", {4'd0, vram_addr, vram_data}, 32'd0);
        rst_n = 1'b1;

        // Single write from c0 right after reset.
        @(negedge clk);
        c0_req = 1'b1;
        serve(2'd0, A0, D0, 1'b0);
        @(negedge clk);
        check("single_no_regrant", 32'(vram_we), 32'd0);

        // Round-robin: last owner was c0, so c1 goes first, then alternation.
        keep0  = 1'b1;
        keep1  = 1'b1;
        c0_req = 1'b1;
        c1_req = 1'b1;
        serve(2'd1, A1, D1, 1'b0);
        serve(2'd0, A0, D0, 1'b0);
        serve(2'd1, A1, D1, 1'b0);
        keep0 = 1'b0;
        keep1 = 1'b0;
        serve(2'd0, A0, D0, 1'b0);
        @(negedge clk);
        check("rr_quiet", 32'(vram_we), 32'd0);

        // Row 29 clear, with an ignored start for row 3 in the middle.
        clr_start = 1'b1;
        clr_row   = 5'd29;
        for (int col = 0; col < 80; col++) begin
            logic [6:0] c;
            c = 7'(col);
            serve(2'd2, {c, 5'd29}, DCL, col == 79);
            if (col == 40) begin
                clr_start = 1'b1;
                clr_row   = 5'd3;
            end
        end
        @(negedge clk);
        check("clr_single_done", 32'({clr_done, clr_busy, vram_we}), 32'd0);

        // Clear of row 29 under continuous contention: 2,0,1,2,0,1...
        clr_start = 1'b1;
        clr_row   = 5'd29;
        serve(2'd2, {7'd0, 5'd29}, DCL, 1'b0);
        c0_req = 1'b1;
        c1_req = 1'b1;
        keep0  = 1'b1;
        keep1  = 1'b1;
        for (int col = 1; col < 80; col++) begin
            logic [6:0] c;
            c = 7'(col);
            serve(2'd0, A0, D0, 1'b0);
            serve(2'd1, A1, D1, 1'b0);
            if (col == 79) begin
                keep0 = 1'b0;
                keep1 = 1'b0;
            end
            serve(2'd2, {c, 5'd29}, DCL, col == 79);
        end
        serve(2'd0, A0, D0, 1'b0);
        @(negedge clk);
        check("cont_quiet", 32'({clr_done, clr_busy, vram_we}), 32'd0);

        // Reset during the second WRITE cycle of a c1 write, with a clear running.
        c1_req    = 1'b1;
        clr_start = 1'b1;
        clr_row   = 5'd7;
        @(negedge clk);
        clr_start = 1'b0;
        check("rst_pre_grant", 32'({vram_we, grant, clr_busy}), 32'b1011);
        @(negedge clk);
        check("rst_pre_we2", 32'(vram_we), 32'd1);
        rst_n  = 1'b0;
        c1_req = 1'b0;
        @(negedge clk);
        check("rst_mid_a", 32'({vram_we, vram_ce, grant, c0_ack, c1_ack, clr_busy, clr_done}), 32'd0);
        check("rst_mid_b", {4'd0, vram_addr, vram_data}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_no_ack_done", 32'({vram_we, c0_ack, c1_ack, clr_done, clr_busy}), 32'd0);
        end
        c0_req = 1'b1;
        c1_req = 1'b1;
        serve(2'd0, A0, D0, 1'b0);
        serve(2'd1, A1, D1, 1'b0);
        @(negedge clk);
        check("final_quiet", 32'(vram_we), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/djs130_vram_arb.md
# djs130_vram_arb

Write-port arbiter and sequencer for the character VRAM of the DJS130 display subsystem. It shares the single VRAM write port among two external requesters (client 0 is the TTO, client 1 is a second display writer) and an internal row-clear engine that fills one text row with blank characters. Arbitration is round-robin among the three. Every granted access is a fixed-length write burst followed by a one-cycle acknowledge.

## Interface
Parameters:
- `WR_CYCLES`, default 3: number of cycles `o_vram_we`/`o_vram_ce` are held high per write (1..15).
- `CLR_COLS`, default 7'd80: number of columns written by one row clear.
- `CLR_CHAR`, default 8'd32: character code written by the clear engine.
- `CLR_COLOR`, default 8'hff: colour byte written by the clear engine.

Ports:
- `i_vram_clk`, input, 1: the only clock; all logic on its rising edge.
- `i_vram_rst_n`, input, 1: reset, synchronous, active-low.
- `i_c0_req`, input, 1: client 0 write request.
- `i_c0_addr`, input, 12: client 0 VRAM address `{col[6:0], row[4:0]}`.
- `i_c0_data`, input, 16: client 0 data `{color, char}`.
- `o_c0_ack`, output, 1: one-cycle pulse when the client 0 write has completed.
- `i_c1_req`, `i_c1_addr`, `i_c1_data`, `o_c1_ack`: same as client 0, for client 1.
- `i_clr_start`, input, 1: starts a row clear.
- `i_clr_row`, input, 5: row to clear; sampled with `i_clr_start`.
- `o_clr_busy`, output, 1: high while a clear is in progress.
- `o_clr_done`, output, 1: one-cycle pulse after the last clear write.
- `o_vram_we`, output, 1: VRAM write enable.
- `o_vram_ce`, output, 1: VRAM chip enable, identical to `o_vram_we`.
- `o_vram_addr`, output, 12: VRAM address.
- `o_vram_data`, output, 16: VRAM write data.
- `o_grant`, output, 2: owner of the current access: 0 = client 0, 1 = client 1, 2 = clear engine. Meaningful only in WRITE and ACK.

## Operation
- The FSM has three states: IDLE, WRITE and ACK.
- **IDLE**
  - The request vector is `{clr_req, i_c1_req, i_c0_req}`. `clr_req` is high while the clear engine is busy.
  - If any request is high, the winner is chosen round-robin, searching upward (with wrap) from `last_grant+1`.
  - On the winning edge the block registers the winner's address and data into `o_vram_addr`/`o_vram_data`, sets `o_grant` and `last_grant`, loads the write counter with `WR_CYCLES`, and moves to WRITE.
  - If no request is high, the block stays in IDLE.
- **WRITE**
  - `o_vram_we` and `o_vram_ce` are high for exactly `WR_CYCLES` cycles. Address and data stay stable throughout.
  - When the counter reaches 1, the FSM goes to ACK.
- **ACK**
  - We and ce are low.
  - For a client grant, that client's `o_cX_ack` is high for this one cycle.
  - For a clear grant, the column counter increments. If the completed column was `CLR_COLS-1`, the clear engine finishes: `o_clr_busy` goes low and `o_clr_done` pulses in the next cycle.
  - The FSM then returns to IDLE.
- **Client handshake**
  - Hold `req`, `addr` and `data` stable until ack.
  - Drop `req` on the edge at which ack is sampled, so `req` is low in the cycle after ack.
  - Dropping `req` before ack is not allowed. A write already granted completes regardless.
- **Clear engine**
  - `i_clr_start` while not busy latches `i_clr_row`, sets the column to 0 and sets `o_clr_busy` on the next edge.
  - `i_clr_start` while busy is ignored.
  - Clear address is `{col, row}`; clear data is `{CLR_COLOR, CLR_CHAR}`.
  - `col` is 7 bits. A clear never wraps past `CLR_COLS-1`.
- **Reset** (`i_vram_rst_n` low at an edge), regardless of state:
  - FSM goes to IDLE; `last_grant` = 2, so client 0 has first priority.
  - All outputs go to 0; `o_grant` = 0.
  - Any write in progress is aborted with no ack.
  - Any clear in progress is aborted with no `o_clr_done`; the column counter and row are cleared.

## Timing
- Request sampled high in IDLE at edge E0:
  - we/ce high in cycles E0+1 through E0+WR_CYCLES.
  - ack in cycle E0+WR_CYCLES+1.
  - Back in IDLE at E0+WR_CYCLES+2.
- One access therefore costs `WR_CYCLES`+2 cycles. With `WR_CYCLES`=3 that is 5 cycles, so a full row clear with no contention takes 400 cycles.
- Contention: under continuous contention each requester is granted at most every third access.
- Simultaneous events: `i_clr_start` arriving in the same cycle as a client grant starts the clear. `clr_req` then joins the arbitration at the next IDLE.
- `o_clr_done` goes high one cycle after the final ACK, and `o_clr_busy` falls in that same cycle.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- **Single write:** after reset, c0 requests addr 12'h03D, data 16'hff41 at E0 → we high for 3 cycles with that addr/data, `o_grant`=0, `o_c0_ack` at E0+4, IDLE at E0+5.
- **Round-robin:** c0 and c1 request continuously (each re-asserting after its ack) → grants alternate 0,1,0,1; each ack goes to the matching client only.
- **Row clear:** `i_clr_start` with row 5'd29 → 80 writes at addr `{col,5'd29}` for col 0..79, all with data 16'hff20, then one `o_clr_done` pulse; busy high throughout.
- **Contention:** during a clear, c0 and c1 request continuously → grant sequence 2,0,1,2,0,1…; the clear still completes after exactly 80 clear writes.
- **Start while busy:** `i_clr_start` with row 5'd3 mid-clear of row 29 → ignored; no writes to row 3, single `o_clr_done`.
- **Reset mid-operation:** assert `i_vram_rst_n`=0 during the second WRITE cycle of a c1 write and during a clear → next cycle all outputs 0, no ack, no done; after release, a c0/c1 simultaneous request grants c0 first.
